// File: rtl/vedic_pkg.sv
// Shared types and arithmetic helpers for the Vedic multiplier datapath stages.
// Used by the dot-product accumulator and its saturating adder.
package vedic_pkg;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } acc_state_e;

  function automatic logic signed [63:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

  // Sign-extend the low prod_w bits of prod to 64 bits; callers truncate to their width.
  function automatic logic signed [63:0] sext(input logic [63:0] prod, input int prod_w);
    logic signed [63:0] t;
    t = $signed(prod << (64 - prod_w));
    return t >>> (64 - prod_w);
  endfunction

endpackage

// File: rtl/vedic_sat_add.sv
// Combinational signed saturating adder: clamps to the signed ACC_W range and
// flags overflow when the ACC_W+1 bit sum does not fit.
module vedic_sat_add
  import vedic_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));

  logic signed [ACC_W:0] wide;

  always_comb begin
    wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf  = wide[ACC_W] ^ wide[ACC_W-1];
    if (ovf) begin
      // top bit of the wide sum carries the true sign of the result
      sum = wide[ACC_W] ? MIN_V : MAX_V;
    end else begin
      sum = wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/vedic_dot_accumulator.sv
// Streaming saturating dot-product stage behind the signed Vedic multiplier:
// sums up to LEN products per vector and hands the result out over valid/ready.
//
//   state  | meaning
//   ST_ACC | accepting products, accumulating into acc
//   ST_OUT | result held on out_*, waiting for out_ready
module vedic_dot_accumulator
  import vedic_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int LEN   = 4,
  parameter  int ACC_W = 20,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*N-1:0]          in_prod,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_sat
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  acc_state_e              state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    sat;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    accept;
  logic                    closing;
  logic                    sat_next;
  logic [CNT_W-1:0]        cnt_next;

  assign prod_ext = ACC_W'(sext(64'(in_prod), 2 * N));
  assign in_ready = (state == ST_ACC) && !rst;
  assign accept   = in_valid && in_ready;
  assign closing  = (cnt == CNT_LAST) || in_last;
  assign sat_next = sat | add_ovf;
  assign cnt_next = cnt + 1'b1;

  vedic_sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .a  (acc),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt_next;
            sat <= sat_next;
            if (closing) begin
              out_sum   <= add_sum;
              out_count <= cnt_next;
              out_sat   <= sat_next;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          // out_* stay frozen until the consumer takes them
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_dot_accumulator.sv
// Bench for vedic_dot_accumulator: two instances (ACC_W=20 and ACC_W=16) share one
// product stream and are checked against a plain-arithmetic saturating dot model.
module tb_vedic_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic               in_ready20, out_valid20, out_sat20;
  logic signed [19:0] out_sum20;
  logic [2:0]         out_count20;
  logic               in_ready16, out_valid16, out_sat16;
  logic signed [15:0] out_sum16;
  logic [2:0]         out_count16;

  int n_cmp = 0;
  int n_err = 0;

  longint vq[$];
  longint exp_sum20, exp_sum16;
  int     exp_cnt;
  bit     exp_sat20, exp_sat16;

  always #5 clk = ~clk;

  vedic_dot_accumulator #(.N(8), .LEN(4), .ACC_W(20)) u_dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid20),
    .out_ready(out_ready), .out_sum(out_sum20), .out_count(out_count20),
    .out_sat(out_sat20)
  );

  vedic_dot_accumulator #(.N(8), .LEN(4), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_sum(out_sum16), .out_count(out_count16),
    .out_sat(out_sat16)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Saturating dot product of vq in a w-bit signed accumulator.
  function automatic void ref_dot(input int w, output longint s, output bit sat);
    longint mx, mn;
    mx  = (64'sd1 <<< (w - 1)) - 1;
    mn  = -mx - 1;
    s   = 0;
    sat = 1'b0;
    foreach (vq[i]) begin
      s = s + vq[i];
      if (s > mx) begin s = mx; sat = 1'b1; end
      else if (s < mn) begin s = mn; sat = 1'b1; end
    end
  endfunction

  task automatic check_result(input string tag);
    ref_dot(20, exp_sum20, exp_sat20);
    ref_dot(16, exp_sum16, exp_sat16);
    exp_cnt = vq.size();
    chk({tag, "_sum20"}, longint'(out_sum20), exp_sum20);
    chk({tag, "_cnt20"}, longint'(out_count20), longint'(exp_cnt));
    chk({tag, "_sat20"}, longint'(out_sat20), longint'(exp_sat20));
    chk({tag, "_sum16"}, longint'(out_sum16), exp_sum16);
    chk({tag, "_cnt16"}, longint'(out_count16), longint'(exp_cnt));
    chk({tag, "_sat16"}, longint'(out_sat16), longint'(exp_sat16));
  endtask

  // Drive the first n entries of vq; optional idle gaps with junk in_last.
  task automatic send_vec(input string tag, input int n, input bit use_last, input int max_gap);
    int t;
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        int gap = int'($urandom_range(0, max_gap));
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_prod  = 16'(vq[i]);
      in_last  = use_last && (i == n - 1);
      t = 0;
      while (!(in_ready20 && in_ready16) && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (t == 20) chk({tag, "_rdy_timeout"}, 0, 1);
      @(posedge clk); #1;
      if (i < n - 1) chk({tag, "_early_valid"}, longint'(out_valid20 | out_valid16), 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_lat20"}, longint'(out_valid20), 1);
    chk({tag, "_lat16"}, longint'(out_valid16), 1);
    check_result(tag);
  endtask

  // Hold the result for `hold` cycles, checking it stays put, then hand it off.
  task automatic drain(input string tag, input int hold);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, longint'(out_valid20 & out_valid16), 1);
      chk({tag, "_hold_rdy"}, longint'(in_ready20 | in_ready16), 0);
      chk({tag, "_hold_sum20"}, longint'(out_sum20), exp_sum20);
      chk({tag, "_hold_sum16"}, longint'(out_sum16), exp_sum16);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained"}, longint'(out_valid20 | out_valid16), 0);
  endtask

  function automatic longint rand_op(input bit extreme);
    if (extreme) return ($urandom_range(0, 1) != 0) ? 127 : -128;
    return longint'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", longint'(in_ready20 | in_ready16), 0);
    chk("rst_valid", longint'(out_valid20 | out_valid16), 0);
    chk("rst_sum", longint'(out_sum20) | longint'(out_sum16), 0);
    chk("rst_cnt", longint'(out_count20 | out_count16), 0);
    chk("rst_sat", longint'(out_sat20 | out_sat16), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", longint'(in_ready20 & in_ready16), 1);

    // back-to-back full vector
    vq = {27 * 5, 12 * 10, -16 * 15, -1 * -1};
    send_vec("t1", 4, 1'b0, 0);
    chk("t1_value", exp_sum20, 16);
    drain("t1", 0);

    // early close on in_last
    vq = {127 * 2, -128 * 2};
    send_vec("t2", 2, 1'b1, 0);
    chk("t2_value", exp_sum20, -2);
    drain("t2", 0);

    // backpressure with a product waiting upstream
    vq = {3 * 4, 5 * 6};
    send_vec("t3", 2, 1'b1, 0);
    in_valid = 1'b1;
    in_prod  = 16'(7 * 7);
    drain("t3", 10);
    vq = {7 * 7, -3, 8, 100};
    send_vec("t3b", 4, 1'b0, 0);
    chk("t3b_value", exp_sum20, 154);
    drain("t3b", 0);

    // clamp in the 16-bit instance, then sticky flag cleared
    vq = {16384, 16384, 16384, 16384};
    send_vec("t4", 4, 1'b0, 0);
    chk("t4_clamp", exp_sum16, 32767);
    drain("t4", 0);
    vq = {1, 1, 1, 1};
    send_vec("t4b", 4, 1'b0, 0);
    drain("t4b", 0);

    // recovery from the clamped value, no wrap
    vq = {16384, 16384, -16384};
    send_vec("t5", 3, 1'b1, 0);
    chk("t5_recover", exp_sum16, 16383);
    drain("t5", 0);

    // reset mid-vector discards the partial sum
    vq = {100, 200};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_prod  = 16'(vq[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_rst_rdy", longint'(in_ready20 | in_ready16), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_no_out", longint'(out_valid20 | out_valid16), 0);
    end
    vq = {1, 1, 1, 1};
    send_vec("t6", 4, 1'b0, 0);
    drain("t6", 0);

    // randomized vectors, lengths, gaps, closes and backpressure
    for (int v = 0; v < 40; v++) begin
      int  n;
      bit  use_last;
      bit  ext;
      n        = int'($urandom_range(1, 4));
      use_last = (n < 4) ? 1'b1 : 1'($urandom);
      ext      = ($urandom_range(0, 2) == 0);
      vq.delete();
      for (int i = 0; i < n; i++) vq.push_back(rand_op(ext) * rand_op(ext));
      send_vec("rnd", n, use_last, 2);
      drain("rnd", int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
